// File: rtl/fir_coef_loader.sv
// fir_coef_loader
//   Turns toggle-framed software commands into writes on the shadow bank of a
//   double-buffered FIR coefficient RAM. The banks swap only on a datapath
//   frame sync, so the FIR never reads a partially loaded coefficient set.
//
// Ports
//   OPB_Clk      sole clock
//   OPB_Rst      asynchronous active-high reset
//   cmd_word     {toggle[31], cmd[30:28], addr[27:16], data[15:0]}
//   sync_in      datapath frame-start pulse, only looked at in WAIT_SYNC
//   coef_we      shadow RAM write enable
//   coef_bank    bank being written, always the inverse of active_bank
//   coef_addr    shadow RAM write address
//   coef_data    shadow RAM write data
//   active_bank  bank the FIR reads
//   swap_pulse   one-cycle pulse when the banks swap
//   busy         high whenever the sequencer is not idle
//   status_word  {ack_toggle, state[2:0], err_cmd, err_addr, err_tmo,
//                 active_bank, swap_count[7:0], wr_count[15:0]}
module fir_coef_loader #(
    parameter int NTAPS    = 256,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int SYNC_TMO = 65535
) (
    input  logic              OPB_Clk,
    input  logic              OPB_Rst,
    input  logic [31:0]       cmd_word,
    input  logic              sync_in,
    output logic              coef_we,
    output logic              coef_bank,
    output logic [ADDR_W-1:0] coef_addr,
    output logic [DATA_W-1:0] coef_data,
    output logic              active_bank,
    output logic              swap_pulse,
    output logic              busy,
    output logic [31:0]       status_word
);

    localparam int TMO_W = $clog2(SYNC_TMO + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SYNC_TMO - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NTAPS - 1);
    localparam logic [12:0]       NTAPS_EXT = 13'(NTAPS);

    localparam logic [2:0] CMD_NOP     = 3'd0;
    localparam logic [2:0] CMD_WRITE   = 3'd1;
    localparam logic [2:0] CMD_CLEAR   = 3'd2;
    localparam logic [2:0] CMD_COMMIT  = 3'd3;
    localparam logic [2:0] CMD_CLR_ERR = 3'd4;

    // Encodings are visible to software through status_word[30:28].
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_CLEAR     = 3'd2,
        ST_WAIT_SYNC = 3'd3
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       cmd_q, cmd_d;
    logic              ack_q, ack_d;
    logic              coef_we_q, coef_we_d;
    logic [ADDR_W-1:0] coef_addr_q, coef_addr_d;
    logic [DATA_W-1:0] coef_data_q, coef_data_d;
    logic              active_q, active_d;
    logic              swap_pulse_q, swap_pulse_d;
    logic              err_cmd_q, err_cmd_d;
    logic              err_addr_q, err_addr_d;
    logic              err_tmo_q, err_tmo_d;
    logic [7:0]        swap_count_q, swap_count_d;
    logic [15:0]       wr_count_q, wr_count_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic [2:0]  cmd_op;
    logic [11:0] cmd_addr;
    logic [15:0] cmd_data;
    logic        cmd_new;
    logic        addr_ok;

    assign cmd_op   = cmd_q[30:28];
    assign cmd_addr = cmd_q[27:16];
    assign cmd_data = cmd_q[15:0];
    // A command stays pending until acknowledged, so a toggle that flips while
    // busy is naturally picked up on the first idle cycle with whatever the
    // register holds by then.
    assign cmd_new  = (cmd_q[31] != ack_q);
    // One extra bit keeps the range check correct when NTAPS is 4096.
    assign addr_ok  = ({1'b0, cmd_addr} < NTAPS_EXT);

    // Next-state and registered-output logic. Write strobes and the swap
    // pulse default low so they only last the single cycle that sets them.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_word;
        ack_d        = ack_q;
        coef_we_d    = 1'b0;
        coef_addr_d  = coef_addr_q;
        coef_data_d  = coef_data_q;
        active_d     = active_q;
        swap_pulse_d = 1'b0;
        err_cmd_d    = err_cmd_q;
        err_addr_d   = err_addr_q;
        err_tmo_d    = err_tmo_q;
        swap_count_d = swap_count_q;
        wr_count_d   = wr_count_q;
        tmo_d        = tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_new) begin
                    ack_d = cmd_q[31];
                    case (cmd_op)
                        CMD_NOP: begin
                        end
                        CMD_WRITE: begin
                            if (addr_ok) begin
                                state_d     = ST_WRITE;
                                coef_we_d   = 1'b1;
                                coef_addr_d = cmd_addr[ADDR_W-1:0];
                                coef_data_d = cmd_data[DATA_W-1:0];
                                if (wr_count_q != 16'hFFFF) begin
                                    wr_count_d = wr_count_q + 16'd1;
                                end
                            end else begin
                                err_addr_d = 1'b1;
                            end
                        end
                        CMD_CLEAR: begin
                            state_d     = ST_CLEAR;
                            coef_we_d   = 1'b1;
                            coef_addr_d = '0;
                            coef_data_d = '0;
                        end
                        CMD_COMMIT: begin
                            state_d = ST_WAIT_SYNC;
                            tmo_d   = '0;
                        end
                        CMD_CLR_ERR: begin
                            err_cmd_d  = 1'b0;
                            err_addr_d = 1'b0;
                            err_tmo_d  = 1'b0;
                        end
                        default: begin
                            err_cmd_d = 1'b1;
                        end
                    endcase
                end
            end

            ST_WRITE: begin
                state_d = ST_IDLE;
            end

            // The address register doubles as the sweep counter.
            ST_CLEAR: begin
                if (coef_addr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    coef_we_d   = 1'b1;
                    coef_addr_d = coef_addr_q + ADDR_W'(1);
                end
            end

            // A sync on the final allowed cycle still wins over the timeout.
            ST_WAIT_SYNC: begin
                if (sync_in) begin
                    state_d      = ST_IDLE;
                    active_d     = ~active_q;
                    swap_pulse_d = 1'b1;
                    swap_count_d = swap_count_q + 8'd1;
                    wr_count_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = ST_IDLE;
                    err_tmo_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any sequence in flight immediately.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            ack_q        <= 1'b0;
            coef_we_q    <= 1'b0;
            coef_addr_q  <= '0;
            coef_data_q  <= '0;
            active_q     <= 1'b0;
            swap_pulse_q <= 1'b0;
            err_cmd_q    <= 1'b0;
            err_addr_q   <= 1'b0;
            err_tmo_q    <= 1'b0;
            swap_count_q <= '0;
            wr_count_q   <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            ack_q        <= ack_d;
            coef_we_q    <= coef_we_d;
            coef_addr_q  <= coef_addr_d;
            coef_data_q  <= coef_data_d;
            active_q     <= active_d;
            swap_pulse_q <= swap_pulse_d;
            err_cmd_q    <= err_cmd_d;
            err_addr_q   <= err_addr_d;
            err_tmo_q    <= err_tmo_d;
            swap_count_q <= swap_count_d;
            wr_count_q   <= wr_count_d;
            tmo_q        <= tmo_d;
        end
    end

    assign coef_we     = coef_we_q;
    assign coef_addr   = coef_addr_q;
    assign coef_data   = coef_data_q;
    assign active_bank = active_q;
    assign coef_bank   = ~active_q;
    assign swap_pulse  = swap_pulse_q;
    assign busy        = (state_q != ST_IDLE);
    assign status_word = {ack_q, state_q, err_cmd_q, err_addr_q, err_tmo_q,
                          active_q, swap_count_q, wr_count_q};

endmodule
